// File: rtl/booth_mul_arbiter_if.sv
// Requester and response channels of the shared Booth multiplier arbiter.
// The flattened operand buses put requester i at bits [32i+31:32i].
interface booth_mul_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    localparam int DATA_W = 32;

    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ-1:0]          req_ready;
    logic [DATA_W*N_REQ-1:0]   req_a;
    logic [DATA_W*N_REQ-1:0]   req_b;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic signed [2*DATA_W-1:0] rsp_result;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result
    );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin sequencer that time-shares one external Booth multiplier among
// N_REQ requesters and returns each tagged 64-bit product on one channel.
module booth_mul_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ID_W       = 2,
    parameter int MUL_CYCLES = 32
) (
    input  logic                clk,
    input  logic                reset,
    booth_mul_arbiter_if.slave  bus,
    output logic                busy,
    output logic                mul_reset,
    output logic                mul_en,
    output logic signed [31:0]  mul_a,
    output logic signed [31:0]  mul_b,
    input  logic signed [63:0]  mul_result
);
    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(MUL_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t                     state, state_nxt;
    logic [ID_W-1:0]            rr_ptr;
    logic [ID_W-1:0]            gnt_idx;
    logic [N_REQ-1:0]           gnt;
    logic                       gnt_any;
    logic [CNT_W-1:0]           cnt;
    logic [ID_W-1:0]            rsp_id;
    logic signed [2*DATA_W-1:0] rsp_result;
    logic                       accept;
    logic                       rsp_fire;
    logic                       run_last;

    // First valid requester at or above rr_ptr, wrapping modulo N_REQ
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!gnt_any && bus.req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
                gnt[(int'(rr_ptr) + k) % N_REQ] = 1'b1;
            end
        end
    end

    assign accept   = (state == IDLE) && gnt_any;
    assign rsp_fire = (state == DONE) && bus.rsp_ready;
    assign run_last = (cnt == CNT_W'(MUL_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)        state_nxt = LOAD;
            LOAD:                    state_nxt = RUN;
            RUN:  if (run_last)      state_nxt = DONE;
            DONE: if (bus.rsp_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Control outputs decode straight from state so an async reset drops them at once
    always_comb begin
        bus.req_ready = (state == IDLE) ? gnt : '0;
        bus.rsp_valid = (state == DONE);
        busy          = (state != IDLE);
        mul_reset     = (state == LOAD);
        mul_en        = (state == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr     <= '0;
            cnt        <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
        end else begin
            if (accept) begin
                mul_a  <= bus.req_a[int'(gnt_idx)*DATA_W +: DATA_W];
                mul_b  <= bus.req_b[int'(gnt_idx)*DATA_W +: DATA_W];
                rsp_id <= gnt_idx;
            end
            if (state == LOAD)     cnt <= '0;
            else if (state == RUN) cnt <= cnt + 1'b1;
            if ((state == RUN) && run_last) rsp_result <= mul_result;
            // Next search starts just past the requester that was served
            if (rsp_fire) rr_ptr <= (rsp_id == ID_W'(N_REQ - 1)) ? '0 : rsp_id + 1'b1;
        end
    end

    assign bus.rsp_id     = rsp_id;
    assign bus.rsp_result = rsp_result;
endmodule
